// File: rtl/result_shifter.sv
// Captures a WIDTH-bit compressor result FILL cycles after start and streams it
// out as OUT_W-bit beats, least significant beat first, with valid/ready flow control.
module result_shifter #(
  parameter int WIDTH = 56,
  parameter int OUT_W = 8,
  parameter int FILL  = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dst,
  output logic             busy,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int BEATS  = WIDTH / OUT_W;
  localparam int CNT_W  = (FILL > 1) ? $clog2(FILL) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_SEND
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [WIDTH-1:0]   data_buf_q, data_buf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      data_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      data_buf_q <= data_buf_d;
    end
  end

  // The last-beat transfer returns to IDLE, so a start on that edge is not seen.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    data_buf_d = data_buf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      end
      ST_FILL: begin
        if (cnt_q == CNT_W'(FILL - 1)) begin
          data_buf_d = dst;
          beat_d     = '0;
          cnt_d      = '0;
          state_d    = ST_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          data_buf_d = data_buf_q >> OUT_W;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_d  = '0;
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_SEND);
  assign out_last  = out_valid && (beat_q == BEAT_W'(BEATS - 1));
  assign out_data  = out_valid ? data_buf_q[OUT_W-1:0] : '0;

endmodule

// File: tb/tb_result_shifter.sv
// Directed self-checking bench for result_shifter at default parameters.
module tb_result_shifter;

  localparam int WIDTH = 56;
  localparam int OUT_W = 8;
  localparam int FILL  = 28;
  localparam int BEATS = 7;

  localparam logic [WIDTH-1:0] D0 = 56'h0123456789ABCD;
  localparam logic [WIDTH-1:0] D1 = 56'hFEDCBA98765432;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dst;
  logic             busy;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  int checks = 0;
  int fails  = 0;

  logic [7:0] exp0 [BEATS] = '{8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
  logic [7:0] exp1 [BEATS] = '{8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};

  always #5 clk = ~clk;

  result_shifter #(.WIDTH(WIDTH), .OUT_W(OUT_W), .FILL(FILL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dst      (dst),
    .busy     (busy),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, out_valid, out_last, out_data} !== 11'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", {busy, out_valid, out_last, out_data}, 11'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL first_start_after_reset: busy got %b expected 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL reset_in_fill: got %b expected 00", {busy, out_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    dst       = D0;
    out_ready = 1'b1;
    pulse_start();
    checks++;
    if ({busy, out_valid} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL basic_fill_entry: got %b expected 10", {busy, out_valid});
    end
    repeat (FILL - 1) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_valid_before_capture: got %b expected 0", out_valid);
    end
    tick();
    for (int k = 0; k < BEATS; k++) begin
      checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, (k == BEATS - 1), exp0[k]}) begin
        fails++;
        $display("[TB] FAIL basic_beat%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                 k, out_valid, out_last, out_data, (k == BEATS - 1), exp0[k]);
      end
      tick();
    end
    checks++;
    if ({busy, out_valid, out_last, out_data} !== 11'b0) begin
      fails++;
      $display("[TB] FAIL basic_idle_after: got %b expected 0", {busy, out_valid, out_last, out_data});
    end
  endtask

  task automatic test_backpressure();
    dst       = D0;
    out_ready = 1'b1;
    pulse_start();
    repeat (FILL) tick();
    for (int k = 0; k < BEATS; k++) begin
      checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, (k == BEATS - 1), exp0[k]}) begin
        fails++;
        $display("[TB] FAIL bp_beat%0d: got v=%b l=%b d=%h expected d=%h",
                 k, out_valid, out_last, out_data, exp0[k]);
      end
      if (k == 2) begin
        out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          tick();
          checks++;
          if ({out_valid, out_last, out_data} !== {2'b10, 8'h89}) begin
            fails++;
            $display("[TB] FAIL bp_hold%0d: got v=%b l=%b d=%h expected v=1 l=0 d=89",
                     h, out_valid, out_last, out_data);
          end
        end
        out_ready = 1'b1;
      end
      tick();
    end
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL bp_idle_after: got %b expected 00", {busy, out_valid});
    end
  endtask

  task automatic test_late_input();
    dst       = 56'hDEADBEEFCAFE11;
    out_ready = 1'b1;
    pulse_start();
    repeat (FILL - 2) tick();
    dst = D1;
    tick();
    tick();
    dst = D0;
    for (int k = 0; k < BEATS; k++) begin
      checks++;
      if ({out_valid, out_data} !== {1'b1, exp1[k]}) begin
        fails++;
        $display("[TB] FAIL late_beat%0d: got v=%b d=%h expected v=1 d=%h",
                 k, out_valid, out_data, exp1[k]);
      end
      tick();
    end
  endtask

  task automatic test_ignored_start();
    logic seen;
    dst       = D0;
    out_ready = 1'b1;
    pulse_start();
    repeat (9) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (FILL - 11) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ign_valid_before_capture: got %b expected 0", out_valid);
    end
    tick();
    for (int k = 0; k < BEATS; k++) begin
      checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, (k == BEATS - 1), exp0[k]}) begin
        fails++;
        $display("[TB] FAIL ign_beat%0d: got v=%b l=%b d=%h expected d=%h",
                 k, out_valid, out_last, out_data, exp0[k]);
      end
      if (k == 3) start = 1'b1;
      tick();
      start = 1'b0;
    end
    seen = 1'b0;
    repeat (FILL + 10) begin
      if (busy || out_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ign_no_second_transfer: activity got %b expected 0", seen);
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    dst       = D0;
    out_ready = 1'b1;
    pulse_start();
    repeat (FILL + 3) tick();
    checks++;
    if (out_data !== 8'h67) begin
      fails++;
      $display("[TB] FAIL abort_beat3: got %h expected 67", out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid, out_last, out_data} !== 11'b0) begin
      fails++;
      $display("[TB] FAIL abort_outputs: got %b expected 0", {busy, out_valid, out_last, out_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (FILL + BEATS + 5) begin
      tick();
      if (busy || out_valid || (out_data != 8'h00)) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_no_partial: activity got %b expected 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    dst       = D0;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    repeat (FILL) tick();
    for (int k = 0; k < BEATS; k++) begin
      checks++;
      if ({out_valid, out_data} !== {1'b1, exp0[k]}) begin
        fails++;
        $display("[TB] FAIL b2b_first_beat%0d: got v=%b d=%h expected d=%h", k, out_valid, out_data, exp0[k]);
      end
      tick();
    end
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL b2b_idle_gap: got %b expected 00", {busy, out_valid});
    end
    tick();
    checks++;
    if ({busy, out_valid} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL b2b_refill: got %b expected 10", {busy, out_valid});
    end
    repeat (FILL - 1) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_valid_before_capture: got %b expected 0", out_valid);
    end
    start = 1'b0;
    tick();
    for (int k = 0; k < BEATS; k++) begin
      checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, (k == BEATS - 1), exp0[k]}) begin
        fails++;
        $display("[TB] FAIL b2b_second_beat%0d: got v=%b l=%b d=%h expected d=%h",
                 k, out_valid, out_last, out_data, exp0[k]);
      end
      tick();
    end
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL b2b_idle_after: got %b expected 00", {busy, out_valid});
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    dst       = '0;
    #1 rst_n  = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_late_input();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
